// File: rtl/bus_checker_mc.sv
`default_nettype none
// ============================================================================
// bus_checker_mc : per-terminal scoreboard matching sent vs. observed transfers
// Rev 1.0 - initial release
// ============================================================================
module bus_checker_mc #(
  parameter int         DRIVERS   = 4,
  parameter int         WIDTH     = 32,
  parameter int         DEPTH     = 8,
  parameter logic [7:0] BROADCAST = {8{1'b1}},
  parameter int         TIMEOUT   = 1024,
  parameter int         TSW       = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       exp_valid_i,
  output logic                       exp_ready_o,
  input  logic [7:0]                 exp_dest_i,
  input  logic [WIDTH-1:0]           exp_data_i,
  input  logic                       rcv_valid_i,
  output logic                       rcv_ready_o,
  input  logic [$clog2(DRIVERS)-1:0] rcv_term_i,
  input  logic [WIDTH-1:0]           rcv_data_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [1:0]                 res_kind_o,
  output logic [$clog2(DRIVERS)-1:0] res_term_o,
  output logic [WIDTH-1:0]           res_data_o,
  output logic [TSW-1:0]             res_latency_o,
  output logic [15:0]                cnt_ok_o,
  output logic [15:0]                cnt_err_o,
  output logic [15:0]                cnt_to_o
);
  localparam int TW = $clog2(DRIVERS);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] KIND_MATCH = 2'b00;
  localparam logic [1:0] KIND_UNEXP = 2'b01;
  localparam logic [1:0] KIND_TMO   = 2'b10;

  // Each terminal keeps its entries packed at the low indices, slot 0 oldest.
  logic [CW-1:0]    cnt_q   [DRIVERS];
  logic [CW-1:0]    cnt_d   [DRIVERS];
  logic [WIDTH-1:0] data_q  [DRIVERS][DEPTH];
  logic [WIDTH-1:0] data_d  [DRIVERS][DEPTH];
  logic [TSW-1:0]   stamp_q [DRIVERS][DEPTH];
  logic [TSW-1:0]   stamp_d [DRIVERS][DEPTH];

  logic [TSW-1:0]   ts_q, ts_d;
  logic [TW-1:0]    rr_q, rr_d;
  logic             res_valid_q, res_valid_d;
  logic [1:0]       res_kind_q, res_kind_d;
  logic [TW-1:0]    res_term_q, res_term_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [TSW-1:0]   res_lat_q, res_lat_d;
  logic [15:0]      ok_q, ok_d, err_q, err_d, to_q, to_d;

  logic [DRIVERS-1:0] full, rm_sel, enq_sel;
  logic [CW-1:0]      wr_pos [DRIVERS];
  logic               is_bcast, dest_ok, dest_full, exp_fire, drop;
  logic               res_free, rcv_fire, res_hs, to_fire, rm_en;
  logic               hit, old_valid;
  logic [IW-1:0]      hit_idx, rm_idx;
  logic [TW-1:0]      rm_term;
  logic [WIDTH-1:0]   old_data;
  logic [TSW-1:0]     hit_stamp, old_stamp, old_age;

  function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    dest_full = 1'b0;
    for (int t = 0; t < DRIVERS; t++) begin
      full[t] = (cnt_q[t] == CW'(DEPTH));
      if (exp_dest_i == 8'(t)) dest_full = full[t];
    end
  end

  assign is_bcast    = (exp_dest_i == BROADCAST);
  assign dest_ok     = !is_bcast && (exp_dest_i < 8'(DRIVERS));
  assign exp_ready_o = rst_ni & (is_bcast ? ~|full : (dest_ok ? ~dest_full : 1'b1));
  assign exp_fire    = exp_valid_i & exp_ready_o;
  assign drop        = exp_fire & ~is_bcast & ~dest_ok;
  assign res_free    = ~res_valid_q | res_ready_i;
  assign rcv_ready_o = rst_ni & res_free;
  assign rcv_fire    = rcv_valid_i & rcv_ready_o;
  assign res_hs      = res_valid_q & res_ready_i;

  // Descending scan so the lowest (oldest) matching slot wins.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    hit_stamp = '0;
    old_valid = 1'b0;
    old_data  = '0;
    old_stamp = '0;
    for (int t = 0; t < DRIVERS; t++) begin
      if (rcv_term_i == TW'(t)) begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if ((CW'(i) < cnt_q[t]) && (data_q[t][i] == rcv_data_i)) begin
            hit       = 1'b1;
            hit_idx   = IW'(i);
            hit_stamp = stamp_q[t][i];
          end
        end
      end
      if (rr_q == TW'(t)) begin
        old_valid = (cnt_q[t] != '0);
        old_data  = data_q[t][0];
        old_stamp = stamp_q[t][0];
      end
    end
  end

  assign old_age = ts_q - old_stamp;
  assign to_fire = old_valid && (old_age >= TSW'(TIMEOUT)) && res_free && !rcv_fire;
  assign rm_en   = (rcv_fire && hit) || to_fire;
  assign rm_term = rcv_fire ? rcv_term_i : rr_q;
  assign rm_idx  = rcv_fire ? hit_idx : '0;

  // Removal is applied before the enqueue position is chosen, but readiness
  // was already decided on the pre-removal occupancy.
  always_comb begin
    for (int t = 0; t < DRIVERS; t++) begin
      rm_sel[t]  = rm_en && (rm_term == TW'(t));
      enq_sel[t] = exp_fire && (is_bcast || (exp_dest_i == 8'(t)));
      wr_pos[t]  = cnt_q[t] - (rm_sel[t] ? CW'(1) : CW'(0));
    end
  end

  always_comb begin
    data_d  = data_q;
    stamp_d = stamp_q;
    for (int t = 0; t < DRIVERS; t++) begin
      cnt_d[t] = wr_pos[t] + (enq_sel[t] ? CW'(1) : CW'(0));
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (rm_sel[t] && (IW'(i) >= rm_idx)) begin
          data_d[t][i]  = data_q[t][i+1];
          stamp_d[t][i] = stamp_q[t][i+1];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_sel[t] && (CW'(i) == wr_pos[t])) begin
          data_d[t][i]  = exp_data_i;
          stamp_d[t][i] = ts_q;
        end
      end
    end
  end

  always_comb begin
    res_valid_d = res_valid_q & ~res_ready_i;
    res_kind_d  = res_kind_q;
    res_term_d  = res_term_q;
    res_data_d  = res_data_q;
    res_lat_d   = res_lat_q;
    if (rcv_fire) begin
      res_valid_d = 1'b1;
      res_kind_d  = hit ? KIND_MATCH : KIND_UNEXP;
      res_term_d  = rcv_term_i;
      res_data_d  = rcv_data_i;
      res_lat_d   = hit ? (ts_q - hit_stamp) : '0;
    end else if (to_fire) begin
      res_valid_d = 1'b1;
      res_kind_d  = KIND_TMO;
      res_term_d  = rr_q;
      res_data_d  = old_data;
      res_lat_d   = old_age;
    end
    ok_d = sat_add(ok_q, {1'b0, res_hs && (res_kind_q == KIND_MATCH)});
    err_d = sat_add(err_q, {1'b0, res_hs && (res_kind_q == KIND_UNEXP)} + {1'b0, drop});
    to_d = sat_add(to_q, {1'b0, res_hs && (res_kind_q == KIND_TMO)});
    ts_d = ts_q + TSW'(1);
    rr_d = (rr_q == TW'(DRIVERS - 1)) ? '0 : rr_q + TW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < DRIVERS; t++) cnt_q[t] <= '0;
      ts_q        <= '0;
      rr_q        <= '0;
      res_valid_q <= 1'b0;
      res_kind_q  <= '0;
      res_term_q  <= '0;
      res_data_q  <= '0;
      res_lat_q   <= '0;
      ok_q        <= '0;
      err_q       <= '0;
      to_q        <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ts_q        <= ts_d;
      rr_q        <= rr_d;
      res_valid_q <= res_valid_d;
      res_kind_q  <= res_kind_d;
      res_term_q  <= res_term_d;
      res_data_q  <= res_data_d;
      res_lat_q   <= res_lat_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      to_q        <= to_d;
    end
  end

  // Slot payloads need no reset: occupancy counts alone define validity.
  always_ff @(posedge clk_i) begin
    data_q  <= data_d;
    stamp_q <= stamp_d;
  end

  assign res_valid_o   = res_valid_q;
  assign res_kind_o    = res_kind_q;
  assign res_term_o    = res_term_q;
  assign res_data_o    = res_data_q;
  assign res_latency_o = res_lat_q;
  assign cnt_ok_o      = ok_q;
  assign cnt_err_o     = err_q;
  assign cnt_to_o      = to_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_checker_mc.sv
`default_nettype none
// ============================================================================
// tb_bus_checker_mc : self-checking bench for bus_checker_mc
// Rev 1.0 - initial release
// ============================================================================
module tb_bus_checker_mc;
  localparam int         DRV = 4;
  localparam int         W   = 16;
  localparam int         DEP = 4;
  localparam int         TO  = 16;
  localparam int         TS  = 8;
  localparam logic [7:0] BC  = 8'hFF;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          exp_valid_i = 1'b0, exp_ready_o;
  logic [7:0]    exp_dest_i = '0;
  logic [W-1:0]  exp_data_i = '0;
  logic          rcv_valid_i = 1'b0, rcv_ready_o;
  logic [1:0]    rcv_term_i = '0;
  logic [W-1:0]  rcv_data_i = '0;
  logic          res_valid_o, res_ready_i = 1'b0;
  logic [1:0]    res_kind_o, res_term_o;
  logic [W-1:0]  res_data_o;
  logic [TS-1:0] res_latency_o;
  logic [15:0]   cnt_ok_o, cnt_err_o, cnt_to_o;

  always #5 clk = ~clk;

  bus_checker_mc #(.DRIVERS(DRV), .WIDTH(W), .DEPTH(DEP), .BROADCAST(BC),
                   .TIMEOUT(TO), .TSW(TS)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o), .exp_dest_i(exp_dest_i),
    .exp_data_i(exp_data_i), .rcv_valid_i(rcv_valid_i), .rcv_ready_o(rcv_ready_o),
    .rcv_term_i(rcv_term_i), .rcv_data_i(rcv_data_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_kind_o(res_kind_o), .res_term_o(res_term_o),
    .res_data_o(res_data_o), .res_latency_o(res_latency_o), .cnt_ok_o(cnt_ok_o),
    .cnt_err_o(cnt_err_o), .cnt_to_o(cnt_to_o));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one FIFO-ordered queue per terminal plus a result slot.
  logic [W-1:0]  qd [DRV][$];
  int            qs [DRV][$];
  int            m_ts, m_cyc;
  bit            m_rv;
  logic [1:0]    m_kind, m_term;
  logic [W-1:0]  m_data;
  logic [TS-1:0] m_lat;
  logic [15:0]   m_ok, m_err, m_to;
  bit            m_exp_rdy, m_rcv_rdy, obs_exp_rdy, obs_rcv_rdy;

  function automatic logic [15:0] inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < DRV; t++) begin
      qd[t].delete();
      qs[t].delete();
    end
    m_ts = 0; m_cyc = 0; m_rv = 0; m_kind = 0; m_term = 0; m_data = 0; m_lat = 0;
    m_ok = 0; m_err = 0; m_to = 0;
  endtask

  task automatic do_reset();
    exp_valid_i = 0; rcv_valid_i = 0; res_ready_i = 0;
    rst_ni = 0;
    repeat (2) @(negedge clk);
    rst_ni = 1;
    model_reset();
  endtask

  // Drive one cycle of inputs, sample the combinational readies, advance the model.
  task automatic cycle(input bit ev, input logic [7:0] ed, input logic [W-1:0] edat,
                       input bit rv, input logic [1:0] rt, input logic [W-1:0] rdat,
                       input bit rr);
    bit any_full, ef, rf, hs;
    int idx, t;
    logic [TS-1:0] age;
    exp_valid_i = ev; exp_dest_i = ed; exp_data_i = edat;
    rcv_valid_i = rv; rcv_term_i = rt; rcv_data_i = rdat; res_ready_i = rr;
    #1;
    obs_exp_rdy = exp_ready_o;
    obs_rcv_rdy = rcv_ready_o;
    any_full = 0;
    for (int k = 0; k < DRV; k++) if (qd[k].size() == DEP) any_full = 1;
    if (ed == BC) m_exp_rdy = !any_full;
    else if (ed < DRV) m_exp_rdy = (qd[int'(ed)].size() < DEP);
    else m_exp_rdy = 1;
    m_rcv_rdy = !m_rv || rr;
    ef = ev && m_exp_rdy;
    rf = rv && m_rcv_rdy;
    hs = m_rv && rr;
    if (hs) begin
      if (m_kind == 2'd0) m_ok = inc16(m_ok);
      else if (m_kind == 2'd1) m_err = inc16(m_err);
      else m_to = inc16(m_to);
    end
    if (ef && ed != BC && ed >= DRV) m_err = inc16(m_err);
    if (rf) begin
      idx = -1;
      for (int i = 0; i < qd[rt].size(); i++) if (idx < 0 && qd[rt][i] == rdat) idx = i;
      m_rv = 1; m_term = rt; m_data = rdat;
      if (idx >= 0) begin
        m_kind = 2'd0;
        m_lat  = TS'(m_ts - qs[rt][idx]);
        qd[rt].delete(idx);
        qs[rt].delete(idx);
      end else begin
        m_kind = 2'd1;
        m_lat  = 0;
      end
    end else begin
      t = m_cyc % DRV;
      age = 0;
      if (qd[t].size() > 0) age = TS'(m_ts - qs[t][0]);
      if (qd[t].size() > 0 && age >= TO && m_rcv_rdy) begin
        m_rv = 1; m_kind = 2'd2; m_term = 2'(t); m_data = qd[t][0]; m_lat = age;
        void'(qd[t].pop_front());
        void'(qs[t].pop_front());
      end else if (hs) begin
        m_rv = 0;
      end
    end
    if (ef)
      for (int k = 0; k < DRV; k++)
        if (ed == BC || int'(ed) == k) begin
          qd[k].push_back(edat);
          qs[k].push_back(m_ts);
        end
    m_ts = (m_ts + 1) % (1 << TS);
    m_cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_valid_i = 1; exp_dest_i = 8'd1; rcv_valid_i = 1; res_ready_i = 1;
    rst_ni = 0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({exp_ready_o, rcv_ready_o, res_valid_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ready got exp=%b rcv=%b res_v=%b want 000", exp_ready_o, rcv_ready_o, res_valid_o);
    end
    n_tests++;
    if (res_kind_o !== 0 || res_term_o !== 0 || res_data_o !== 0 || res_latency_o !== 0) begin
      n_fail++;
      $display("FAIL reset_fields got k=%0d t=%0d d=%h l=%0d want all 0", res_kind_o, res_term_o, res_data_o, res_latency_o);
    end
    n_tests++;
    if (cnt_ok_o !== 0 || cnt_err_o !== 0 || cnt_to_o !== 0) begin
      n_fail++;
      $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", cnt_ok_o, cnt_err_o, cnt_to_o);
    end
    @(negedge clk);
    rst_ni = 1;
    model_reset();
    cycle(0, 8'd0, '0, 0, 2'd0, '0, 1);
    n_tests++;
    if (obs_exp_rdy !== 1'b1 || obs_rcv_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release got exp=%b rcv=%b want 1 1", obs_exp_rdy, obs_rcv_rdy);
    end
  endtask

  task automatic test_match();
    do_reset();
    cycle(1, 8'd1, 16'd1, 0, 2'd0, '0, 1);
    cycle(1, 8'd1, 16'd2, 0, 2'd0, '0, 1);
    repeat (3) cycle(0, 8'd0, '0, 0, 2'd0, '0, 1);
    cycle(0, 8'd0, '0, 1, 2'd1, 16'd2, 0);
    n_tests++;
    if (res_valid_o !== 1 || res_kind_o !== 2'd0 || res_term_o !== 2'd1 || res_data_o !== 16'd2 ||
        res_latency_o !== 8'd4 || m_lat !== 8'd4) begin
      n_fail++;
      $display("FAIL match_second got v=%b k=%0d t=%0d d=%0d l=%0d want 1 0 1 2 4",
               res_valid_o, res_kind_o, res_term_o, res_data_o, res_latency_o);
    end
    cycle(0, 8'd0, '0, 0, 2'd0, '0, 1);
    cycle(0, 8'd0, '0, 1, 2'd1, 16'd1, 1);
    n_tests++;
    if (res_valid_o !== 1 || res_kind_o !== 2'd0 || res_data_o !== 16'd1 || res_latency_o !== 8'd7) begin
      n_fail++;
      $display("FAIL match_remaining got v=%b k=%0d d=%0d l=%0d want 1 0 1 7",
               res_valid_o, res_kind_o, res_data_o, res_latency_o);
    end
    cycle(0, 8'd0, '0, 0, 2'd0, '0, 1);
    n_tests++;
    if (cnt_ok_o !== 16'd2 || res_valid_o !== 0) begin
      n_fail++;
      $display("FAIL match_count got ok=%0d v=%b want 2 0", cnt_ok_o, res_valid_o);
    end
  endtask

  task automatic test_unexpected();
    do_reset();
    cycle(0, 8'd0, '0, 1, 2'd0, 16'd5, 0);
    n_tests++;
    if (res_valid_o !== 1 || res_kind_o !== 2'd1 || res_term_o !== 2'd0 || res_data_o !== 16'd5 ||
        res_latency_o !== 8'd0) begin
      n_fail++;
      $display("FAIL unexpected_res got v=%b k=%0d t=%0d d=%0d l=%0d want 1 1 0 5 0",
               res_valid_o, res_kind_o, res_term_o, res_data_o, res_latency_o);
    end
    cycle(0, 8'd0, '0, 0, 2'd0, '0, 1);
    n_tests++;
    if (cnt_err_o !== 16'd1 || cnt_ok_o !== 16'd0 || res_valid_o !== 0) begin
      n_fail++;
      $display("FAIL unexpected_count got err=%0d ok=%0d v=%b want 1 0 0", cnt_err_o, cnt_ok_o, res_valid_o);
    end
    cycle(1, 8'd9, 16'd3, 0, 2'd0, '0, 1);
    n_tests++;
    if (obs_exp_rdy !== 1 || cnt_err_o !== 16'd2) begin
      n_fail++;
      $display("FAIL invalid_dest got rdy=%b err=%0d want 1 2", obs_exp_rdy, cnt_err_o);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEP; i++) cycle(1, 8'd2, W'(10 + i), 0, 2'd0, '0, 1);
    cycle(1, 8'd2, 16'd99, 0, 2'd0, '0, 1);
    n_tests++;
    if (obs_exp_rdy !== 0) begin n_fail++; $display("FAIL full_dest2 got %b want 0", obs_exp_rdy); end
    cycle(0, 8'd3, '0, 0, 2'd0, '0, 1);
    n_tests++;
    if (obs_exp_rdy !== 1) begin n_fail++; $display("FAIL full_dest3 got %b want 1", obs_exp_rdy); end
    cycle(0, BC, '0, 0, 2'd0, '0, 1);
    n_tests++;
    if (obs_exp_rdy !== 0) begin n_fail++; $display("FAIL full_bcast got %b want 0", obs_exp_rdy); end
    cycle(1, 8'd2, 16'd50, 1, 2'd2, 16'd10, 1);
    n_tests++;
    if (obs_exp_rdy !== 0 || res_kind_o !== 2'd0 || res_data_o !== 16'd10) begin
      n_fail++;
      $display("FAIL full_no_bypass got rdy=%b k=%0d d=%0d want 0 0 10", obs_exp_rdy, res_kind_o, res_data_o);
    end
    cycle(0, 8'd2, '0, 0, 2'd0, '0, 1);
    n_tests++;
    if (obs_exp_rdy !== 1) begin n_fail++; $display("FAIL full_freed got %b want 1", obs_exp_rdy); end
  endtask

  task automatic test_broadcast();
    do_reset();
    cycle(1, BC, 16'd7, 0, 2'd0, '0, 1);
    n_tests++;
    if (obs_exp_rdy !== 1) begin n_fail++; $display("FAIL bcast_ready got %b want 1", obs_exp_rdy); end
    for (int t = 0; t < DRV; t++) begin
      cycle(0, 8'd0, '0, 1, 2'(t), 16'd7, 1);
      n_tests++;
      if (res_valid_o !== 1 || res_kind_o !== 2'd0 || res_term_o !== 2'(t) || res_data_o !== 16'd7 ||
          res_latency_o !== TS'(t + 1)) begin
        n_fail++;
        $display("FAIL bcast_term%0d got v=%b k=%0d t=%0d d=%0d l=%0d want 1 0 %0d 7 %0d",
                 t, res_valid_o, res_kind_o, res_term_o, res_data_o, res_latency_o, t, t + 1);
      end
    end
    cycle(0, 8'd0, '0, 0, 2'd0, '0, 1);
    n_tests++;
    if (cnt_ok_o !== 16'd4) begin n_fail++; $display("FAIL bcast_count got %0d want 4", cnt_ok_o); end
    for (int t = 0; t < DRV; t++) begin
      cycle(0, 8'd0, '0, 1, 2'(t), 16'd7, 1);
      n_tests++;
      if (res_kind_o !== 2'd1) begin
        n_fail++;
        $display("FAIL bcast_empty%0d got kind %0d want 1", t, res_kind_o);
      end
    end
  endtask

  task automatic test_timeout();
    bit found;
    do_reset();
    cycle(1, 8'd0, 16'h55, 0, 2'd0, '0, 1);
    found = 0;
    for (int n = 0; n < TO + DRV && !found; n++) begin
      cycle(0, 8'd0, '0, 0, 2'd0, '0, 1);
      if (res_valid_o === 1'b1) found = 1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL timeout_seen got none within %0d cycles want kind 2 result", TO + DRV);
    end else if (res_kind_o !== 2'd2 || res_term_o !== 2'd0 || res_data_o !== 16'h55 ||
                 res_latency_o !== 8'd16 || m_rv !== 1) begin
      n_fail++;
      $display("FAIL timeout_res got k=%0d t=%0d d=%h l=%0d want 2 0 55 16",
               res_kind_o, res_term_o, res_data_o, res_latency_o);
    end
    cycle(0, 8'd0, '0, 0, 2'd0, '0, 1);
    n_tests++;
    if (cnt_to_o !== 16'd1 || cnt_err_o !== 16'd0) begin
      n_fail++;
      $display("FAIL timeout_count got to=%0d err=%0d want 1 0", cnt_to_o, cnt_err_o);
    end
  endtask

  task automatic test_stall_reset();
    do_reset();
    cycle(0, 8'd0, '0, 1, 2'd1, 16'd9, 0);
    for (int n = 0; n < 5; n++) begin
      cycle(1, 8'd1, 16'd3, 1, 2'd1, 16'd3, 0);
      n_tests++;
      if (obs_rcv_rdy !== 0 || res_valid_o !== 1 || res_kind_o !== 2'd1 || res_term_o !== 2'd1 ||
          res_data_o !== 16'd9 || res_latency_o !== 8'd0) begin
        n_fail++;
        $display("FAIL stall_hold%0d got rdy=%b v=%b k=%0d t=%0d d=%0d l=%0d want 0 1 1 1 9 0",
                 n, obs_rcv_rdy, res_valid_o, res_kind_o, res_term_o, res_data_o, res_latency_o);
      end
    end
    #3;
    rst_ni = 0;
    #1;
    n_tests++;
    if (exp_ready_o !== 0 || rcv_ready_o !== 0 || res_valid_o !== 0 || res_kind_o !== 0 ||
        res_term_o !== 0 || res_data_o !== 0 || res_latency_o !== 0 || cnt_ok_o !== 0 ||
        cnt_err_o !== 0 || cnt_to_o !== 0) begin
      n_fail++;
      $display("FAIL midreset got er=%b rr=%b v=%b k=%0d d=%0d ok=%0d err=%0d want all 0",
               exp_ready_o, rcv_ready_o, res_valid_o, res_kind_o, res_data_o, cnt_ok_o, cnt_err_o);
    end
    exp_valid_i = 0; rcv_valid_i = 0; res_ready_i = 0;
    repeat (2) @(negedge clk);
    rst_ni = 1;
    model_reset();
    cycle(0, 8'd1, '0, 1, 2'd1, 16'd3, 1);
    n_tests++;
    if (obs_exp_rdy !== 1 || obs_rcv_rdy !== 1 || res_valid_o !== 1 || res_kind_o !== 2'd1) begin
      n_fail++;
      $display("FAIL post_reset got er=%b rr=%b v=%b k=%0d want 1 1 1 1",
               obs_exp_rdy, obs_rcv_rdy, res_valid_o, res_kind_o);
    end
  endtask

  task automatic test_random();
    logic [7:0] ed;
    int r, bad_rdy, bad_res, bad_cnt;
    do_reset();
    bad_rdy = 0; bad_res = 0; bad_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      if (r < 7) ed = 8'(r % DRV);
      else if (r < 9) ed = BC;
      else ed = 8'(4 + $urandom_range(0, 250));
      cycle($urandom_range(0, 1) == 1, ed, W'($urandom_range(0, 5)),
            $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), W'($urandom_range(0, 5)),
            $urandom_range(0, 3) != 0);
      n_tests++;
      if (obs_exp_rdy !== m_exp_rdy || obs_rcv_rdy !== m_rcv_rdy) begin
        n_fail++;
        if (bad_rdy++ < 5)
          $display("FAIL rand_ready c=%0d got %b%b want %b%b", c, obs_exp_rdy, obs_rcv_rdy, m_exp_rdy, m_rcv_rdy);
      end
      n_tests++;
      if (res_valid_o !== m_rv || (m_rv && (res_kind_o !== m_kind || res_term_o !== m_term ||
          res_data_o !== m_data || res_latency_o !== m_lat))) begin
        n_fail++;
        if (bad_res++ < 5)
          $display("FAIL rand_result c=%0d got v=%b k=%0d t=%0d d=%0d l=%0d want v=%b k=%0d t=%0d d=%0d l=%0d",
                   c, res_valid_o, res_kind_o, res_term_o, res_data_o, res_latency_o,
                   m_rv, m_kind, m_term, m_data, m_lat);
      end
      n_tests++;
      if (cnt_ok_o !== m_ok || cnt_err_o !== m_err || cnt_to_o !== m_to) begin
        n_fail++;
        if (bad_cnt++ < 5)
          $display("FAIL rand_counters c=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                   c, cnt_ok_o, cnt_err_o, cnt_to_o, m_ok, m_err, m_to);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_match();
    test_unexpected();
    test_full();
    test_broadcast();
    test_timeout();
    test_stall_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
